// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock controller.
//   cpu_state_e        : FSM state encoding (PAUSE=0, RUN=1, STEP=2, HALT=3)
//   FAST_DIV_LOG2_DEF  : default fast-mode divider exponent
//   SLOW_DIV_LOG2_DEF  : default slow-mode divider exponent
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } cpu_state_e;

    localparam int unsigned FAST_DIV_LOG2_DEF = 3;
    localparam int unsigned SLOW_DIV_LOG2_DEF = 26;

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// rising-edge detector.
//   clk     : sampling clock
//   rst     : asynchronous, active-high reset (debounced level = 0)
//   btn_i   : raw, bouncy, asynchronous button input
//   pulse_o : one-clk pulse when the debounced level goes 0 -> 1
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // The counter tracks consecutive cycles where the synchronized input
    // disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        level_d = level_q;
        pulse_d = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
                pulse_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run / pause / single-step controller for the CPU clock enable.
//   clk         : 100 MHz board clock
//   rst         : asynchronous, active-high reset
//   run_sw      : 1 = run, 0 = pause (asynchronous switch)
//   slow_sw     : 1 = slow rate, 0 = fast rate (asynchronous switch)
//   step_btn    : single-step push button (asynchronous, bouncy)
//   halt_req    : CPU halt request, level, synchronous to clk
//   cpu_ce      : one-clk clock-enable pulses for the CPU
//   state       : PAUSE=0, RUN=1, STEP=2, HALT=3
//   running     : high while in RUN
//   cycle_count : number of cpu_ce pulses issued (wraps)
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned FAST_DIV_LOG2   = FAST_DIV_LOG2_DEF,
    parameter int unsigned SLOW_DIV_LOG2   = SLOW_DIV_LOG2_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             slow_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned    PW        = SLOW_DIV_LOG2;
    localparam logic [PW-1:0]  FAST_MASK = PW'((64'd1 << FAST_DIV_LOG2) - 64'd1);
    localparam logic [PW-1:0]  SLOW_MASK = '1;

    logic             run_meta_q, run_s_q;
    logic             slow_meta_q, slow_s_q;
    logic             step_pulse;
    logic             slow_chg;
    logic             terminal;
    logic [PW-1:0]    div_mask;

    cpu_state_e       state_q;
    logic             cpu_ce_q;
    logic [PW-1:0]    pre_q;
    logic [CNT_W-1:0] count_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (step_btn),
        .pulse_o(step_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_meta_q  <= 1'b0;
            run_s_q     <= 1'b0;
            slow_meta_q <= 1'b0;
            slow_s_q    <= 1'b0;
        end else begin
            run_meta_q  <= run_sw;
            run_s_q     <= run_meta_q;
            slow_meta_q <= slow_sw;
            slow_s_q    <= slow_meta_q;
        end
    end

    // slow_chg is high on the edge at which slow_s_q takes its new value, so
    // the prescaler restarts exactly when the new rate becomes effective.
    assign slow_chg = slow_meta_q ^ slow_s_q;
    assign div_mask = slow_s_q ? SLOW_MASK : FAST_MASK;
    assign terminal = ((pre_q & div_mask) == div_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= PAUSE;
            cpu_ce_q <= 1'b0;
            pre_q    <= '0;
            count_q  <= '0;
        end else begin
            cpu_ce_q <= 1'b0;
            // Held at zero outside RUN, which also clears it on RUN entry.
            pre_q    <= '0;
            case (state_q)
                PAUSE: begin
                    if (run_s_q && !halt_req) begin
                        state_q <= RUN;
                    end else if (step_pulse) begin
                        state_q  <= STEP;
                        cpu_ce_q <= 1'b1;
                        count_q  <= count_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_q <= HALT;
                    end else if (!run_s_q) begin
                        state_q <= PAUSE;
                    end else if (!slow_chg) begin
                        // A rate change restarts the period (no pulse on that edge).
                        pre_q <= pre_q + PW'(1);
                        if (terminal) begin
                            cpu_ce_q <= 1'b1;
                            count_q  <= count_q + CNT_W'(1);
                        end
                    end
                end
                STEP: begin
                    state_q <= PAUSE;
                end
                HALT: begin
                    if (!run_s_q) begin
                        state_q <= PAUSE;
                    end
                end
                default: begin
                    state_q <= PAUSE;
                end
            endcase
        end
    end

    assign cpu_ce      = cpu_ce_q;
    assign state       = state_q;
    assign running     = (state_q == RUN);
    assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl (FAST=3, SLOW=5, DEBOUNCE=4, CNT_W=4).
module tb_cpu_clk_ctrl;

    localparam int unsigned FAST = 3;
    localparam int unsigned SLOW = 5;
    localparam int unsigned DEB  = 4;
    localparam int unsigned CW   = 4;

    localparam logic [1:0] S_PAUSE = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          run_sw   = 1'b0;
    logic          slow_sw  = 1'b0;
    logic          step_btn = 1'b0;
    logic          halt_req = 1'b0;
    logic          cpu_ce;
    logic [1:0]    state;
    logic          running;
    logic [CW-1:0] cycle_count;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(
        .FAST_DIV_LOG2  (FAST),
        .SLOW_DIV_LOG2  (SLOW),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_sw     (run_sw),
        .slow_sw    (slow_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .running    (running),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Switch effects appear two edges after the pin; the step button is
    // accepted after DEB consecutive disagreeing samples; in RUN a pulse is
    // due whenever the cycles elapsed since entry / rate change is a
    // multiple of the current period.
    logic [1:0]    m_state;
    logic          m_ce;
    logic [CW-1:0] m_cnt;
    logic [1:0]    run_h, slow_h, btn_h;
    logic          m_deb, m_stp;
    int            m_diff, m_elapsed;

    always @(posedge clk or posedge rst) begin : model
        logic [1:0] ns;
        logic       ce, run_s, slow_s, slow_nx, bsync;
        if (rst) begin
            m_state   <= S_PAUSE;
            m_ce      <= 1'b0;
            m_cnt     <= '0;
            run_h     <= '0;
            slow_h    <= '0;
            btn_h     <= '0;
            m_deb     <= 1'b0;
            m_stp     <= 1'b0;
            m_diff    <= 0;
            m_elapsed <= 0;
        end else begin
            run_s   = run_h[1];
            slow_s  = slow_h[1];
            slow_nx = slow_h[0];
            bsync   = btn_h[1];
            ns      = m_state;
            ce      = 1'b0;
            case (m_state)
                S_PAUSE: if (run_s && !halt_req) ns = S_RUN; else if (m_stp) ns = S_STEP;
                S_RUN:   if (halt_req) ns = S_HALT; else if (!run_s) ns = S_PAUSE;
                S_STEP:  ns = S_PAUSE;
                default: if (!run_s) ns = S_PAUSE;
            endcase
            if (ns == S_STEP) ce = 1'b1;
            if (m_state == S_RUN && ns == S_RUN) begin
                if (slow_nx != slow_s) begin
                    m_elapsed <= 0;
                end else begin
                    m_elapsed <= m_elapsed + 1;
                    if (((m_elapsed + 1) % (1 << (slow_s ? SLOW : FAST))) == 0) ce = 1'b1;
                end
            end else begin
                m_elapsed <= 0;
            end
            m_state <= ns;
            m_ce    <= ce;
            m_cnt   <= m_cnt + CW'(ce);
            if (bsync != m_deb) begin
                if (m_diff + 1 == DEB) begin
                    m_deb  <= bsync;
                    m_stp  <= bsync;
                    m_diff <= 0;
                end else begin
                    m_stp  <= 1'b0;
                    m_diff <= m_diff + 1;
                end
            end else begin
                m_stp  <= 1'b0;
                m_diff <= 0;
            end
            run_h  <= {run_h[0], run_sw};
            slow_h <= {slow_h[0], slow_sw};
            btn_h  <= {btn_h[0], step_btn};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_state",   state,       m_state);
            chk("model_ce",      cpu_ce,      m_ce);
            chk("model_running", running,     m_state == S_RUN);
            chk("model_count",   cycle_count, m_cnt);
        end
    end

    // One clock edge, then check state / cpu_ce against hand expectations.
    task automatic edge_chk(input string tag, input logic [1:0] es, input logic ece);
        @(negedge clk);
        chk({tag, "_state"}, state, es);
        chk({tag, "_ce"}, cpu_ce, ece);
        if (ece) exp_cnt = exp_cnt + CW'(1);
    endtask

    typedef struct {
        logic       run;
        logic       halt;
        logic       btn;
        int         edges;
        logic [1:0] es;
        logic       ece;
    } vec_t;

    function automatic vec_t mk(logic r, logic h, logic b, int n, logic [1:0] es, logic ece);
        vec_t v;
        v.run = r; v.halt = h; v.btn = b; v.edges = n; v.es = es; v.ece = ece;
        return v;
    endfunction

    initial begin
        vec_t vt[$];
        // PAUSE arbitration: run vs step in the same clk, then halt blocking RUN
        vt.push_back(mk(1'b0, 1'b0, 1'b1, 4, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b1, 2, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b1, 1, S_RUN,   1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b1, 3, S_RUN,   1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 4, S_RUN,   1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 1, S_RUN,   1'b1));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 3, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b0, 1'b0, 1'b0, 4, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 6, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 1, S_STEP,  1'b1));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 1, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 1'b1, 2, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b1, 1'b0, 8, S_PAUSE, 1'b0));
        vt.push_back(mk(1'b1, 1'b0, 1'b0, 1, S_RUN,   1'b0));

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_state",   state,       S_PAUSE);
        chk("rst_ce",      cpu_ce,      1'b0);
        chk("rst_running", running,     1'b0);
        chk("rst_count",   cycle_count, 0);

        // 1: fast run, RUN 3 clk after run_sw, pulse every 8
        run_sw = 1'b1;
        slow_sw = 1'b0;
        for (int e = 1; e <= 83; e++)
            edge_chk("t1", (e < 3) ? S_PAUSE : S_RUN, (e > 3) && (((e - 3) % 8) == 0));
        chk("t1_count10", cycle_count, 10);
        chk("t1_running", running, 1'b1);

        // 2: switch to slow, next pulse 32 clk after the synchronized change
        slow_sw = 1'b1;
        for (int j = 1; j <= 66; j++)
            edge_chk("t2", S_RUN, (j == 34) || (j == 66));
        chk("t2_count", cycle_count, exp_cnt);

        // 3: pause, bouncy step press, then a second press
        run_sw = 1'b0;
        for (int e = 1; e <= 3; e++)
            edge_chk("t3_stop", (e < 3) ? S_RUN : S_PAUSE, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            step_btn = (e == 1) || (e >= 3 && e <= 12);
            edge_chk("t3_bounce", (e == 9) ? S_STEP : S_PAUSE, e == 9);
        end
        chk("t3_count1", cycle_count, exp_cnt);
        for (int e = 1; e <= 20; e++) begin
            step_btn = (e <= 10);
            edge_chk("t3_press2", (e == 7) ? S_STEP : S_PAUSE, e == 7);
        end
        chk("t3_count2", cycle_count, exp_cnt);

        // 4: halt on a terminal count, step ignored, release via run_sw
        slow_sw = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            logic [1:0] es;
            run_sw   = (e <= 31) || (e >= 35 && e <= 45);
            halt_req = (e == 11);
            step_btn = (e >= 12 && e <= 21);
            if (e <= 2)       es = S_PAUSE;
            else if (e <= 10) es = S_RUN;
            else if (e <= 33) es = S_HALT;
            else if (e <= 36) es = S_PAUSE;
            else if (e <= 47) es = S_RUN;
            else              es = S_PAUSE;
            edge_chk("t4", es, e == 45);
        end
        chk("t4_count", cycle_count, exp_cnt);

        // 5: table-driven PAUSE arbitration
        foreach (vt[i]) begin
            run_sw   = vt[i].run;
            halt_req = vt[i].halt;
            step_btn = vt[i].btn;
            repeat (vt[i].edges) @(negedge clk);
            chk($sformatf("t5_vec%0d_state", i), state, vt[i].es);
            chk($sformatf("t5_vec%0d_ce", i), cpu_ce, vt[i].ece);
            if (vt[i].ece) exp_cnt = exp_cnt + CW'(1);
        end
        chk("t5_count", cycle_count, exp_cnt);

        // Randomized run against the reference model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(199) == 0) run_sw = ~run_sw;
            if ($urandom_range(299) == 0) slow_sw = ~slow_sw;
            halt_req = ($urandom_range(79) == 0);
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
            @(negedge clk);
        end

        // 6: counter wrap and asynchronous reset mid-run
        #1 rst = 1'b1;
        run_sw = 1'b0; slow_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sw = 1'b1;
        exp_cnt = '0;
        for (int e = 1; e <= 139; e++)
            edge_chk("t6", (e < 3) ? S_PAUSE : S_RUN, (e > 3) && (((e - 3) % 8) == 0));
        chk("t6_wrap", cycle_count, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_arst_ce",      cpu_ce,      1'b0);
        chk("t6_arst_state",   state,       S_PAUSE);
        chk("t6_arst_running", running,     1'b0);
        chk("t6_arst_count",   cycle_count, 0);
        run_sw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
